// File: rtl/ultraman_mem_responder.sv
// rtl/ultraman_mem_responder.sv - unified instruction/data RAM and MMIO responder for the Ultraman core
// Port A serves fetch and host load, port B serves loads/stores and the MMIO window.
module ultraman_mem_responder #(
  parameter int ADDR_WIDTH  = 14,
  parameter int PRINT_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_rinst,
  input  logic [31:0] mem_rinst_addr,
  output logic [31:0] mem_rdata_instr,
  input  logic        mem_wren,
  input  logic        mem_rden,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  input  logic        prog_wren,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_wdata,
  output logic        print_valid,
  output logic [7:0]  print_data,
  input  logic        print_ready,
  output logic        print_overflow,
  output logic        finish
);

  localparam int PW = $clog2(PRINT_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(PRINT_DEPTH);

  logic [31:0] ram [2**ADDR_WIDTH];
  logic [31:0] instr_word_q;
  logic [31:0] data_word_q;

  logic [ADDR_WIDTH-1:0] a_idx;
  logic [ADDR_WIDTH-1:0] b_idx;
  logic                  mmio_sel;
  logic                  reg_hit;
  logic                  ram_rd_b;
  logic                  ram_wr_b;
  logic                  mmio_rd;
  logic                  push_req;
  logic                  push_ok;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [31:0]           mmio_rdata;

  logic          instr_vld_q, instr_vld_d;
  logic          data_src_ram_q, data_src_ram_d;
  logic [31:0]   mmio_rdata_q, mmio_rdata_d;
  logic [31:0]   cycle_q, cycle_d;
  logic          finish_q, finish_d;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [7:0]    fifo_mem [PRINT_DEPTH];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr, mem_rinst_addr, prog_addr};

  always_comb begin
    a_idx      = prog_wren ? prog_addr[ADDR_WIDTH+1:2] : mem_rinst_addr[ADDR_WIDTH+1:2];
    b_idx      = mem_addr[ADDR_WIDTH+1:2];
    mmio_sel   = (mem_addr[31:28] == 4'h1);
    reg_hit    = (mem_addr[31:8] == 24'h10_0000);
    ram_rd_b   = mem_rden & ~mmio_sel;
    ram_wr_b   = mem_wren & ~mmio_sel;
    mmio_rd    = mem_rden & mmio_sel;
    fifo_full  = (count_q == DEPTH_C);
    fifo_empty = (count_q == '0);
    pop        = ~fifo_empty & print_ready;
    push_req   = mem_wren & reg_hit & (mem_addr[3:2] == 2'd0) & mem_wstrb[0];
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    push_ok    = push_req & (~fifo_full | pop);
  end

  always_comb begin
    mmio_rdata = 32'h0;
    if (reg_hit) begin
      case (mem_addr[3:2])
        2'd1:    mmio_rdata = {31'b0, finish_q};
        2'd2:    mmio_rdata = cycle_q;
        2'd3:    mmio_rdata = {29'b0, overflow_q, fifo_full, fifo_empty};
        default: mmio_rdata = 32'h0;
      endcase
    end
  end

  // Port B write is issued after port A so it wins on a same-index collision;
  // both reads see the pre-edge word.
  always_ff @(posedge clk) begin
    if (prog_wren) begin
      ram[a_idx] <= prog_wdata;
    end else if (mem_rinst) begin
      instr_word_q <= ram[a_idx];
    end
    if (ram_wr_b) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wstrb[i]) ram[b_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
    if (ram_rd_b) data_word_q <= ram[b_idx];
    if (push_ok) fifo_mem[wr_ptr_q] <= mem_wdata[7:0];
  end

  always_comb begin
    instr_vld_d    = instr_vld_q | (mem_rinst & ~prog_wren);
    data_src_ram_d = data_src_ram_q;
    if (ram_rd_b)     data_src_ram_d = 1'b1;
    else if (mmio_rd) data_src_ram_d = 1'b0;
    mmio_rdata_d   = mmio_rd ? mmio_rdata : mmio_rdata_q;
    cycle_d        = cycle_q + 32'd1;
    finish_d       = finish_q | (mem_wren & reg_hit & (mem_addr[3:2] == 2'd1));
    overflow_d     = overflow_q | (push_req & ~push_ok);
    wr_ptr_d       = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d       = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d        = count_q;
    if (push_ok & ~pop)      count_d = count_q + (PW+1)'(1);
    else if (~push_ok & pop) count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      instr_vld_q    <= 1'b0;
      data_src_ram_q <= 1'b0;
      mmio_rdata_q   <= 32'h0;
      cycle_q        <= 32'h0;
      finish_q       <= 1'b0;
      overflow_q     <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      instr_vld_q    <= instr_vld_d;
      data_src_ram_q <= data_src_ram_d;
      mmio_rdata_q   <= mmio_rdata_d;
      cycle_q        <= cycle_d;
      finish_q       <= finish_d;
      overflow_q     <= overflow_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  // RAM output registers carry no reset; the valid/source flags mask them to 0.
  assign mem_rdata_instr = instr_vld_q ? instr_word_q : 32'h0;
  assign mem_rdata       = data_src_ram_q ? data_word_q : mmio_rdata_q;
  assign print_valid     = ~fifo_empty;
  assign print_data      = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];
  assign print_overflow  = overflow_q;
  assign finish          = finish_q;

endmodule

// File: tb/tb_ultraman_mem_responder.sv
// tb/tb_ultraman_mem_responder.sv - directed self-checking bench for ultraman_mem_responder
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_ultraman_mem_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_rinst;
  logic [31:0] mem_rinst_addr;
  logic [31:0] mem_rdata_instr;
  logic        mem_wren;
  logic        mem_rden;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        prog_wren;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;
  logic        print_valid;
  logic [7:0]  print_data;
  logic        print_ready;
  logic        print_overflow;
  logic        finish;

  int errors = 0;
  int checks = 0;
  logic [31:0] c0, c1;

  ultraman_mem_responder #(.ADDR_WIDTH(14), .PRINT_DEPTH(8)) dut (
    .clk(clk), .resetn(resetn),
    .mem_rinst(mem_rinst), .mem_rinst_addr(mem_rinst_addr), .mem_rdata_instr(mem_rdata_instr),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .prog_wren(prog_wren), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .print_valid(print_valid), .print_data(print_data), .print_ready(print_ready),
    .print_overflow(print_overflow), .finish(finish)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    prog_wren = 1'b1; prog_addr = a; prog_wdata = d;
    tick();
    prog_wren = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    mem_rinst = 1'b1; mem_rinst_addr = a;
    tick();
    mem_rinst = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    mem_rden = 1'b1; mem_addr = a;
    tick();
    mem_rden = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_wren = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    tick();
    mem_wren = 1'b0; mem_wstrb = 4'h0;
  endtask

  initial begin
    resetn = 1'b0; mem_rinst = 0; mem_rinst_addr = 0; mem_wren = 0; mem_rden = 0;
    mem_addr = 0; mem_wdata = 0; mem_wstrb = 0; prog_wren = 0; prog_addr = 0;
    prog_wdata = 0; print_ready = 0;
    tick(); tick();
    check("rst_instr", mem_rdata_instr, 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_pvalid", {31'b0, print_valid}, 32'h0);
    check("rst_pdata", {24'b0, print_data}, 32'h0);
    check("rst_ovf", {31'b0, print_overflow}, 32'h0);
    check("rst_finish", {31'b0, finish}, 32'h0);
    resetn = 1'b1;
    tick();

    prog(32'h0000_0000, 32'h0000_0013);
    prog(32'h0000_0004, 32'hCAFE_0000);
    prog(32'h0000_0100, 32'h1122_3344);
    prog(32'h0000_0200, 32'h0000_0005);

    fetch(32'h0000_0000);
    check("fetch_0", mem_rdata_instr, 32'h0000_0013);
    fetch(32'h0000_0100);
    check("fetch_100", mem_rdata_instr, 32'h1122_3344);
    fetch(32'h0001_0000);
    check("fetch_alias", mem_rdata_instr, 32'h0000_0013);
    tick();
    check("instr_hold", mem_rdata_instr, 32'h0000_0013);

    mem_rinst = 1'b1; mem_rinst_addr = 32'h0000_0100;
    prog(32'h0000_0300, 32'hDEAD_BEEF);
    mem_rinst = 1'b0;
    check("prog_prio_hold", mem_rdata_instr, 32'h0000_0013);
    fetch(32'h0000_0300);
    check("fetch_300", mem_rdata_instr, 32'hDEAD_BEEF);

    wr(32'h0000_0100, 32'hAABB_CCDD, 4'b0100);
    rd(32'h0000_0100);
    check("byte_store", mem_rdata, 32'h11BB_3344);
    tick();
    check("rdata_hold", mem_rdata, 32'h11BB_3344);

    mem_rden = 1'b1;
    wr(32'h0000_0200, 32'h0000_0009, 4'hF);
    mem_rden = 1'b0;
    check("rdw_old", mem_rdata, 32'h0000_0005);
    rd(32'h0000_0200);
    check("rdw_new", mem_rdata, 32'h0000_0009);

    mem_rinst = 1'b1; mem_rinst_addr = 32'h0000_0200;
    wr(32'h0000_0200, 32'h0000_0077, 4'hF);
    mem_rinst = 1'b0;
    check("ab_read_old", mem_rdata_instr, 32'h0000_0009);
    mem_wren = 1'b1; mem_addr = 32'h0000_0200; mem_wdata = 32'h0000_2222; mem_wstrb = 4'hF;
    prog(32'h0000_0200, 32'h0000_1111);
    mem_wren = 1'b0; mem_wstrb = 4'h0;
    rd(32'h0000_0200);
    check("ab_write_b_wins", mem_rdata, 32'h0000_2222);

    check("finish_before", {31'b0, finish}, 32'h0);
    wr(32'h1000_0004, 32'h1234_5678, 4'hF);
    check("finish_set", {31'b0, finish}, 32'h1);
    rd(32'h1000_0004);
    check("finish_read", mem_rdata, 32'h0000_0001);
    rd(32'h0000_0004);
    check("mmio_no_ram", mem_rdata, 32'hCAFE_0000);

    rd(32'h1000_0008);
    c0 = mem_rdata;
    tick(); tick(); tick(); tick();
    rd(32'h1000_0008);
    c1 = mem_rdata;
    check("cycle_delta", c1 - c0, 32'd5);

    wr(32'h1000_0000, 32'h0000_005A, 4'b0010);
    check("push_no_strb", {31'b0, print_valid}, 32'h0);
    for (int i = 0; i < 8; i++) wr(32'h1000_0000, 32'h30 + i, 4'b0001);
    rd(32'h1000_000C);
    check("status_full", mem_rdata, 32'h0000_0002);
    print_ready = 1'b1;
    wr(32'h1000_0000, 32'h0000_0038, 4'b0001);
    print_ready = 1'b0;
    check("pushpop_head", {24'b0, print_data}, 32'h31);
    rd(32'h1000_000C);
    check("pushpop_status", mem_rdata, 32'h0000_0002);
    check("pushpop_no_ovf", {31'b0, print_overflow}, 32'h0);
    print_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain1_data", {23'b0, print_valid, print_data}, 32'h131 + i);
      tick();
    end
    print_ready = 1'b0;
    check("drain1_empty", {31'b0, print_valid}, 32'h0);

    wr(32'h1000_0000, 32'h0000_0041, 4'b0001);
    check("push_visible", {23'b0, print_valid, print_data}, 32'h141);
    for (int i = 1; i < 9; i++) wr(32'h1000_0000, 32'h41 + i, 4'b0001);
    check("overflow_set", {31'b0, print_overflow}, 32'h1);
    rd(32'h1000_000C);
    check("status_ovf_full", mem_rdata, 32'h0000_0006);
    rd(32'h1000_0000);
    check("print_read_zero", mem_rdata, 32'h0);
    print_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain2_data", {23'b0, print_valid, print_data}, 32'h141 + i);
      tick();
    end
    print_ready = 1'b0;
    check("drain2_empty", {31'b0, print_valid}, 32'h0);

    wr(32'h1000_0000, 32'h0000_0058, 4'b0001);
    wr(32'h1000_0000, 32'h0000_0059, 4'b0001);
    fetch(32'h0000_0300);
    rd(32'h0000_0100);
    check("pre_rst_rdata", mem_rdata, 32'h11BB_3344);
    resetn = 1'b0;
    #1;
    check("mid_rst_instr", mem_rdata_instr, 32'h0);
    check("mid_rst_rdata", mem_rdata, 32'h0);
    check("mid_rst_pvalid", {31'b0, print_valid}, 32'h0);
    check("mid_rst_pdata", {24'b0, print_data}, 32'h0);
    check("mid_rst_ovf", {31'b0, print_overflow}, 32'h0);
    check("mid_rst_finish", {31'b0, finish}, 32'h0);
    tick();
    resetn = 1'b1;
    rd(32'h1000_0008);
    check("cycle_after_rst0", mem_rdata, 32'h0);
    rd(32'h1000_0008);
    check("cycle_after_rst1", mem_rdata, 32'h1);
    rd(32'h1000_000C);
    check("status_after_rst", mem_rdata, 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
